// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator feed path: word width, feeder FSM
// encoding and lane slicing helper.
package accel_pkg;

    localparam int unsigned WordW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDrain
    } feed_state_e;

    // Low bit index of lane `lane` inside a flat N*w lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/lane_delay.sv
// One systolic lane input: DEPTH+1 register stages carrying a word and its valid.
// Each stage loads data only with a valid word, so outputs hold their last value.
module lane_delay #(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [DEPTH:0]        valid_q;
    logic [DEPTH:0][W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int s = 1; s <= int'(DEPTH); s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign valid_o = valid_q[DEPTH];
    assign data_o  = data_q[DEPTH];

endmodule

// File: rtl/skew_feeder.sv
// Collects word pairs from the dual-port ROM into N-word vectors and launches
// each one into the systolic array edge with lane i delayed by i cycles.
module skew_feeder
    import accel_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = WordW,
    parameter int unsigned ROWS = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [2*W-1:0] in_data_i,
    output logic [N*W-1:0] out_data_o,
    output logic [N-1:0]   out_valid_o,
    output logic           busy_o,
    output logic           done_o
);

    localparam int unsigned PairW  = $clog2(N / 2) + 1;
    localparam int unsigned RowW   = $clog2(ROWS) + 1;
    localparam int unsigned DrainW = $clog2(N) + 1;

    localparam logic [PairW-1:0]  LastPair  = PairW'(N / 2 - 1);
    localparam logic [RowW-1:0]   LastRow   = RowW'(ROWS - 1);
    localparam logic [DrainW-1:0] DrainInit = DrainW'(N - 1);

    feed_state_e           state_q, state_d;
    logic [PairW-1:0]      pair_q, pair_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [DrainW-1:0]     drain_q, drain_d;
    logic                  done_q, done_d;
    logic [N-1:0][W-1:0]   vec_q, vec_d;
    logic                  accept;
    logic                  launch;

    assign accept = (state_q == StFill) && in_valid_i;
    assign launch = accept && (pair_q == LastPair);

    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        row_d   = row_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        vec_d   = vec_q;
        unique case (state_q)
            StIdle: begin
                // done_q high means DRAIN is still being left; a start then is dropped.
                if (start_i && !done_q) begin
                    state_d = StFill;
                    pair_d  = '0;
                    row_d   = '0;
                end
            end
            StFill: begin
                if (accept) begin
                    for (int unsigned k = 0; k < N / 2; k++) begin
                        if (pair_q == PairW'(k)) begin
                            vec_d[2*k]   = in_data_i[W-1:0];
                            vec_d[2*k+1] = in_data_i[2*W-1:W];
                        end
                    end
                    if (launch) begin
                        pair_d = '0;
                        row_d  = row_q + 1'b1;
                        if (row_q == LastRow) begin
                            state_d = StDrain;
                            drain_d = DrainInit;
                        end
                    end else begin
                        pair_d = pair_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pair_q  <= '0;
            row_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            vec_q   <= vec_d;
        end
    end

    assign in_ready_o = (state_q == StFill);
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;

    // vec_d already merges the current pair, so it is the complete vector on a launch beat.
    for (genvar i = 0; i < N; i++) begin : g_lane
        lane_delay #(
            .DEPTH(i),
            .W    (W)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .valid_i(launch),
            .data_i (vec_d[i]),
            .valid_o(out_valid_o[i]),
            .data_o (out_data_o[lane_lsb(i, W) +: W])
        );
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: expected lane words and done cycles are queued
// as beats are driven and retired as the DUT emits them.
module tb_skew_feeder;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned ROWS = 2;

    typedef struct {
        logic [W-1:0] word;
        int           due;
    } exp_t;

    logic           clk      = 1'b0;
    logic           reset    = 1'b1;
    logic           start    = 1'b0;
    logic           in_valid = 1'b0;
    logic [2*W-1:0] in_data  = '0;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic           busy;
    logic           done;

    logic           s2_start = 1'b0;
    logic           s2_valid = 1'b0;
    logic [2*W-1:0] s2_data  = '0;
    logic           s2_ready;
    logic [2*W-1:0] s2_out;
    logic [1:0]     s2_ov;
    logic           s2_busy;
    logic           s2_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bit           m_fill     = 1'b0;
    int           m_pair     = 0;
    int           m_row      = 0;
    int           m_done_due = -1;
    logic [W-1:0] m_vec [N];
    exp_t         lane_q [N][$];
    int           done_due_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    skew_feeder #(.N(N), .W(W), .ROWS(ROWS)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .busy_o     (busy),
        .done_o     (done)
    );

    skew_feeder #(.N(2), .W(W), .ROWS(1)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .start_i    (s2_start),
        .in_valid_i (s2_valid),
        .in_ready_o (s2_ready),
        .in_data_i  (s2_data),
        .out_data_o (s2_out),
        .out_valid_o(s2_ov),
        .busy_o     (s2_busy),
        .done_o     (s2_done)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic int pending();
        int s = done_due_q.size();
        for (int i = 0; i < N; i++) s += lane_q[i].size();
        return s;
    endfunction

    // Drives one cycle of inputs and advances the reference model for that cycle.
    task automatic drive(input bit st, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        @(negedge clk);
        start    = st;
        in_valid = v;
        in_data  = {b, a};
        k = cyc + 1;
        if (st && !m_fill && cyc > m_done_due) begin
            m_fill = 1'b1;
            m_pair = 0;
            m_row  = 0;
        end else if (v && m_fill) begin
            m_vec[2*m_pair]   = a;
            m_vec[2*m_pair+1] = b;
            if (m_pair == N / 2 - 1) begin
                for (int i = 0; i < N; i++) lane_q[i].push_back('{word: m_vec[i], due: k + i});
                m_pair = 0;
                m_row++;
                if (m_row == ROWS) begin
                    m_fill     = 1'b0;
                    m_done_due = k + N;
                    done_due_q.push_back(k + N);
                end
            end else begin
                m_pair++;
            end
        end
    endtask

    task automatic start_tile();
        drive(1'b1, 1'b0, '0, '0);
        @(posedge clk); #1;
        check_eq("start_busy", busy, 1'b1);
        check_eq("start_in_ready", in_ready, 1'b1);
    endtask

    task automatic send_tile(input int base, input int gap, input bit sf, input bit sd);
        for (int r = 0; r < ROWS; r++) begin
            for (int p = 0; p < N / 2; p++) begin
                if (r == 1 && p == 0) repeat (gap) drive(1'b0, 1'b0, '0, '0);
                drive((r == ROWS - 1 && p == 0) ? sf : 1'b0, 1'b1,
                      W'(base + r * N + 2 * p + 1), W'(base + r * N + 2 * p + 2));
            end
        end
        @(posedge clk); #1;
        check_eq("last_in_ready_low", in_ready, 1'b0);
        check_eq("drain_busy", busy, 1'b1);
        if (sd) drive(1'b1, 1'b0, '0, '0);
    endtask

    task automatic wait_drain();
        int budget = 100;
        drive(1'b0, 1'b0, '0, '0);
        while (cyc <= m_done_due && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        check_eq("drain_pending", pending(), 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (out_valid[i]) begin
                if (lane_q[i].size() == 0) begin
                    check_eq($sformatf("spurious_valid%0d", i), out_valid[i], 1'b0);
                end else begin
                    exp_t e;
                    e = lane_q[i].pop_front();
                    check_eq($sformatf("lane%0d_data", i), out_data[i*W +: W], e.word);
                    check_eq($sformatf("lane%0d_cycle", i), cyc, e.due);
                end
            end else if (lane_q[i].size() != 0 && lane_q[i][0].due <= cyc) begin
                check_eq($sformatf("missing_valid%0d", i), out_valid[i], 1'b1);
                void'(lane_q[i].pop_front());
            end
        end
        if (done) begin
            if (done_due_q.size() == 0) begin
                check_eq("spurious_done", done, 1'b0);
            end else begin
                check_eq("done_cycle", cyc, done_due_q.pop_front());
                check_eq("done_busy_low", busy, 1'b0);
            end
        end else if (done_due_q.size() != 0 && done_due_q[0] <= cyc) begin
            check_eq("missing_done", done, 1'b1);
            void'(done_due_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_out_valid", out_valid, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        reset = 1'b0;

        // Two-lane, single-row instance.
        @(negedge clk); s2_start = 1'b1;
        @(negedge clk); s2_start = 1'b0; s2_valid = 1'b1; s2_data = {32'hB, 32'hA};
        @(negedge clk); s2_valid = 1'b0;
        check_eq("n2_valid_a", s2_ov, 2'b01);
        check_eq("n2_lane0", s2_out[W-1:0], 32'hA);
        @(negedge clk);
        check_eq("n2_valid_b", s2_ov, 2'b10);
        check_eq("n2_lane1", s2_out[2*W-1:W], 32'hB);
        check_eq("n2_lane0_hold", s2_out[W-1:0], 32'hA);
        check_eq("n2_no_early_done", s2_done, 1'b0);
        @(negedge clk);
        check_eq("n2_done", s2_done, 1'b1);
        check_eq("n2_busy_low", s2_busy, 1'b0);
        check_eq("n2_valid_idle", s2_ov, 2'b00);

        // Words offered while idle must be ignored.
        drive(1'b0, 1'b1, 32'hDEAD, 32'hDEAD);
        @(posedge clk); #1;
        check_eq("idle_in_ready", in_ready, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
        drive(1'b0, 1'b0, '0, '0);

        start_tile();
        send_tile(0, 0, 1'b0, 1'b0);
        wait_drain();

        start_tile();
        send_tile(16, 3, 1'b0, 1'b0);
        wait_drain();

        // Starts during FILL, DRAIN and the done cycle are all dropped.
        start_tile();
        send_tile(32, 0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        while (cyc < m_done_due - 1) @(negedge clk);
        drive(1'b1, 1'b0, '0, '0);
        @(posedge clk); #1;
        check_eq("done_cycle_start_ignored", busy, 1'b0);
        start_tile();
        send_tile(48, 0, 1'b0, 1'b0);
        wait_drain();

        // Reset with lanes 2/3 of row 0 still in flight and row 1 half loaded.
        start_tile();
        drive(1'b0, 1'b1, 32'd101, 32'd102);
        drive(1'b0, 1'b1, 32'd103, 32'd104);
        drive(1'b0, 1'b1, 32'd105, 32'd106);
        @(negedge clk); #1;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) lane_q[i].delete();
        done_due_q.delete();
        m_fill     = 1'b0;
        m_done_due = -1;
        #2;
        check_eq("mid_rst_out_valid", out_valid, '0);
        check_eq("mid_rst_out_data", out_data, '0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_in_ready", in_ready, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;

        start_tile();
        send_tile(64, 0, 1'b0, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
